// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer between the execute stage and a
// word-wide memory port. It checks width and alignment and builds the byte
// enables and lane-replicated store data. It issues one request and holds it
// until acknowledged, then sign- or zero-extends load data.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start, i_is_store  access request (sampled in IDLE only), store/load select
//   i_funct3             RV32I width code (B/H/W/BU/HU)
//   i_addr, i_wdata      effective byte address, store data
//   o_busy, o_done       FSM not idle, one-cycle completion pulse
//   o_fault, o_rdata     fault flag (valid with done), extended load result
//   o_mem_*              memory request/write/address/byte-enable/write-data
//   i_mem_ack            memory accept; load data valid in the same cycle
//   i_mem_rdata          read word
module load_store_unit #(
   parameter int unsigned LEN = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   input  logic           i_is_store,
   input  logic [2:0]     i_funct3,
   input  logic [LEN-1:0] i_addr,
   input  logic [LEN-1:0] i_wdata,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_fault,
   output logic [LEN-1:0] o_rdata,
   output logic           o_mem_req,
   output logic           o_mem_we,
   output logic [LEN-1:0] o_mem_addr,
   output logic [3:0]     o_mem_be,
   output logic [LEN-1:0] o_mem_wdata,
   input  logic           i_mem_ack,
   input  logic [LEN-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

   state_e         r_state;
   logic           r_busy, r_done, r_fault, r_mem_req, r_mem_we;
   logic           r_is_store;
   logic [2:0]     r_funct3;
   logic [1:0]     r_off;
   logic [LEN-1:0] r_rdata, r_mem_addr, r_mem_wdata;
   logic [3:0]     r_mem_be;

   logic           w_legal, w_misalign;
   logic [3:0]     w_be;
   logic [LEN-1:0] w_wdata, w_ext;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;

   // Request decode on the raw execute-stage inputs.
   always_comb begin
      w_legal    = 1'b0;
      w_misalign = 1'b0;
      w_be       = 4'b0000;
      w_wdata    = i_wdata;
      unique case (i_funct3)
         3'b000, 3'b100: begin
            w_legal = (i_funct3 == 3'b000) || !i_is_store;
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            w_legal    = (i_funct3 == 3'b001) || !i_is_store;
            w_misalign = i_addr[0];
            w_be       = 4'b0011 << i_addr[1:0];
            w_wdata    = {2{i_wdata[15:0]}};
         end
         3'b010: begin
            w_legal    = 1'b1;
            w_misalign = (i_addr[1:0] != 2'b00);
            w_be       = 4'b1111;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Load extraction uses the offset and width latched at start.
   always_comb begin
      w_byte = i_mem_rdata[8*r_off +: 8];
      w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      unique case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'h0, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'h0, w_half};
         default: w_ext = i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_is_store  <= 1'b0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= '0;
      end else begin
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_busy <= 1'b1;
                  if (w_legal && !w_misalign) begin
                     r_state     <= StReq;
                     r_is_store  <= i_is_store;
                     r_funct3    <= i_funct3;
                     r_off       <= i_addr[1:0];
                     r_mem_addr  <= {i_addr[LEN-1:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_is_store;
                  end else begin
                     // Faulting access completes without touching memory.
                     r_state <= StErr;
                     r_done  <= 1'b1;
                     r_fault <= 1'b1;
                  end
               end
            end
            StReq: begin
               if (i_mem_ack) begin
                  r_state   <= StResp;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_done    <= 1'b1;
                  if (!r_is_store) r_rdata <= w_ext;
               end
            end
            StResp, StErr: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_fault     = r_fault;
   assign o_rdata     = r_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule
